// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for instruction memory with length header and XOR checksum
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byteValid,
    input  logic [7:0]        byteData,
    output logic              byteReady,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [15:0]       wrData,
    output logic              cpuRst,
    output logic              done,
    output logic              err,
    output logic [1:0]        errCode,
    output logic [ADDR_W:0]   wordCnt
);
    localparam logic [2:0] LEN_HI  = 3'd0;
    localparam logic [2:0] LEN_LO  = 3'd1;
    localparam logic [2:0] DATA_HI = 3'd2;
    localparam logic [2:0] DATA_LO = 3'd3;
    localparam logic [2:0] CHK     = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
    localparam logic [2:0] ERR     = 3'd6;
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    logic [2:0]  state;
    logic [7:0]  lenhi, hi, xsum;
    logic [15:0] rem, n;
    logic        acc, over;

    assign byteReady = state != DONE && state != ERR;
    assign acc = byteValid && byteReady;
    assign n = {lenhi, byteData};
    assign over = {1'b0, n} > MAX_WORDS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LEN_HI;
            lenhi   <= '0;
            hi      <= '0;
            xsum    <= '0;
            rem     <= '0;
            wrEn    <= 1'b0;
            wrAddr  <= '0;
            wrData  <= '0;
            cpuRst  <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            errCode <= 2'b00;
            wordCnt <= '0;
        end else begin
            wrEn <= 1'b0;
            // address advances once the strobed write has been presented
            if (wrEn) wrAddr <= wrAddr + 1'b1;
            if (!byteReady && start) begin
                state   <= LEN_HI;
                xsum    <= '0;
                wordCnt <= '0;
                wrAddr  <= '0;
                errCode <= 2'b00;
                done    <= 1'b0;
                err     <= 1'b0;
                cpuRst  <= 1'b1;
            end else if (acc) begin
                if (state != CHK) xsum <= xsum ^ byteData;
                case (state)
                    LEN_HI: begin
                        lenhi <= byteData;
                        state <= LEN_LO;
                    end
                    LEN_LO: begin
                        rem   <= n;
                        state <= over ? ERR : n == 16'd0 ? CHK : DATA_HI;
                        if (over) begin
                            err     <= 1'b1;
                            errCode <= 2'b01;
                        end
                    end
                    DATA_HI: begin
                        hi    <= byteData;
                        state <= DATA_LO;
                    end
                    DATA_LO: begin
                        wrEn    <= 1'b1;
                        wrData  <= {hi, byteData};
                        wordCnt <= wordCnt + 1'b1;
                        rem     <= rem - 16'd1;
                        state   <= rem == 16'd1 ? CHK : DATA_HI;
                    end
                    CHK: begin
                        state   <= byteData == xsum ? DONE : ERR;
                        done    <= byteData == xsum;
                        err     <= byteData != xsum;
                        cpuRst  <= byteData != xsum;
                        errCode <= byteData == xsum ? 2'b00 : 2'b10;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams with a write scoreboard checked by a separate monitor
module tb_imem_loader;
    logic       clk = 0, rst = 1, start = 0, byteValid = 0;
    logic [7:0] byteData = 0;
    logic       byteReady, wrEn, cpuRst, done, err;
    logic [7:0] wrAddr;
    logic [15:0] wrData;
    logic [1:0] errCode;
    logic [8:0] wordCnt;

    int total = 0, bad = 0;
    logic [23:0] expq[$];
    logic [7:0]  stim[$];

    imem_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .byteValid(byteValid), .byteData(byteData),
        .byteReady(byteReady), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .cpuRst(cpuRst), .done(done), .err(err), .errCode(errCode), .wordCnt(wordCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (wrEn) begin
            if (expq.size() == 0) check("unexpected write", {8'h0, wrAddr, wrData}, -1);
            else check("write addr/data", {8'h0, wrAddr, wrData}, {8'h0, expq.pop_front()});
        end
    end

    task automatic run_stream(input int maxgap);
        while (stim.size() > 0) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            @(negedge clk);
            if (!byteReady) begin
                check("byteReady during stream", byteReady, 1);
                stim.delete();
                return;
            end
            byteValid = 1;
            byteData = stim.pop_front();
            @(posedge clk);
            #1 byteValid = 0;
        end
        @(negedge clk);
    endtask

    task automatic push_t1();
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        expq.push_back({8'd0, 16'h1234});
        expq.push_back({8'd1, 16'hABCD});
    endtask

    task automatic pulse_start(input logic with_byte);
        @(negedge clk);
        start = 1;
        byteValid = with_byte;
        byteData = 8'hFF;
        @(negedge clk);
        start = 0;
        byteValid = 0;
        check("restart cpuRst", cpuRst, 1);
        check("restart done/err", {done, err, errCode}, 0);
        check("restart wordCnt", wordCnt, 0);
        check("restart byteReady", byteReady, 1);
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        check(name, expq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("reset byteReady", byteReady, 1);
        check("reset outputs", {wrEn, wrAddr, wrData, cpuRst, done, err, errCode, wordCnt},
              {1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'b00, 9'd0});

        // good two-word load
        push_t1();
        run_stream(0);
        check("t1 done", done, 1);
        check("t1 cpuRst", cpuRst, 0);
        check("t1 wordCnt", wordCnt, 2);
        check("t1 err", err, 0);
        drain("t1 writes");

        // same load with a bad checksum
        pulse_start(0);
        push_t1();
        void'(stim.pop_back());
        stim.push_back(8'h43);
        run_stream(0);
        check("t2 err", err, 1);
        check("t2 errCode", errCode, 2);
        check("t2 cpuRst", cpuRst, 1);
        check("t2 byteReady", byteReady, 0);
        check("t2 done", done, 0);
        drain("t2 writes");

        // length 257 overflows a 256-word memory
        pulse_start(0);
        stim = '{8'h01, 8'h01};
        run_stream(0);
        check("t3 err", err, 1);
        check("t3 errCode", errCode, 1);
        check("t3 cpuRst", cpuRst, 1);
        drain("t3 no writes");

        // length exactly 256, word i = {i, ~i}; checksum 0x01
        pulse_start(0);
        stim = '{8'h01, 8'h00};
        for (int i = 0; i < 256; i++) begin
            stim.push_back(8'(i));
            stim.push_back(~8'(i));
            expq.push_back({8'(i), 8'(i), ~8'(i)});
        end
        stim.push_back(8'h01);
        run_stream(0);
        check("tmax done", done, 1);
        check("tmax wordCnt", wordCnt, 256);
        drain("tmax writes");

        // empty load
        pulse_start(0);
        stim = '{8'h00, 8'h00, 8'h00};
        run_stream(0);
        check("t4 done", done, 1);
        check("t4 wordCnt", wordCnt, 0);
        drain("t4 no writes");

        // gapped stream, then stray bytes in DONE
        pulse_start(0);
        push_t1();
        run_stream(3);
        check("t5 done", done, 1);
        check("t5 cpuRst", cpuRst, 0);
        check("t5 wordCnt", wordCnt, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            byteValid = 1;
            byteData = 8'h55;
            check("t5 byteReady in DONE", byteReady, 0);
            @(negedge clk);
            byteValid = 0;
        end
        check("t5 still done", {done, err, wordCnt}, {1'b1, 1'b0, 9'd2});
        drain("t5 writes");

        // restart with a coincident byte, then one-word load
        pulse_start(1);
        stim = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        expq.push_back({8'd0, 16'hBEEF});
        run_stream(0);
        check("t6 cpuRst mid-load", cpuRst, 1);
        stim = '{8'h50};
        run_stream(0);
        check("t6 done", done, 1);
        check("t6 cpuRst", cpuRst, 0);
        drain("t6 writes");

        // reset after three bytes
        pulse_start(0);
        stim = '{8'h00, 8'h02, 8'h12};
        run_stream(0);
        #1 rst = 1;
        #1;
        check("mid-reset outputs", {byteReady, wrEn, wrAddr, wrData, cpuRst, done, err, errCode, wordCnt},
              {1'b1, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'b00, 9'd0});
        @(negedge clk);
        rst = 0;
        push_t1();
        run_stream(0);
        check("t7 done", done, 1);
        check("t7 wordCnt", wordCnt, 2);
        drain("t7 writes");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the CPU's read-only instruction memory.
- Accepts a byte stream on a valid/ready handshake, checks a length header, and assembles big-endian 16-bit instruction words.
- Writes each word to sequential instruction-memory addresses from 0, then verifies an XOR checksum.
- Holds the CPU in reset (cpuRst) until a load completes cleanly.

Parameters:
ADDR_W, 8, instruction-memory address width; capacity MAX_WORDS = 2**ADDR_W words.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; restarts a load from DONE or ERR
byteValid  input  1  byteData holds a valid stream byte
byteData  input  8  stream byte
byteReady  output  1  loader accepts a byte this cycle; transfer occurs when byteValid && byteReady
wrEn  output  1  instruction-memory write strobe, one cycle per word
wrAddr  output  ADDR_W  instruction-memory write address
wrData  output  16  instruction word to write
cpuRst  output  1  holds CPU/pipeline in reset while high
done  output  1  load completed and checksum matched
err  output  1  load failed
errCode  output  2  00 none, 01 length overflow, 10 checksum mismatch
wordCnt  output  ADDR_W+1  words written in the current load

Behaviour:
- Stream format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N words, each sent high byte then low byte.
  - One checksum byte equal to the XOR of every preceding byte in the load, length bytes included.
- States: LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERR.
- byteReady is combinational: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK; 0 in DONE and ERR.
- Transitions (each taken on an accepted byte unless noted):
  - LEN_HI -> LEN_LO.
  - LEN_LO -> ERR (errCode=01) if N > MAX_WORDS.
  - LEN_LO -> CHK if N == 0.
  - LEN_LO -> DATA_HI otherwise.
  - DATA_HI -> DATA_LO; the byte is latched as the word's upper half.
  - DATA_LO -> DATA_HI if words remain, else -> CHK.
  - CHK -> DONE if the byte equals the running XOR.
  - CHK -> ERR (errCode=10) otherwise.
  - DONE/ERR -> LEN_HI on start. The running XOR, wordCnt, wrAddr, errCode, done and err clear, and cpuRst reasserts.
- Running XOR: cleared on reset and start, updated on every accepted byte before CHK.
- Write timing:
  - The cycle after the DATA_LO byte is accepted: wrEn=1 for exactly one cycle, wrData={hi,lo}, wrAddr = index of the word.
  - wrAddr increments after each write; wordCnt increments in the same cycle as wrEn.
  - With continuous byteValid, a word completes every 2 cycles, so there is no back-pressure and byteReady stays high through DATA states.
- Idle cycles (byteValid=0) in any state hold all state; no timeout.
- cpuRst:
  - 1 from reset until the cycle after the CHK byte matches; 0 in DONE.
  - Remains 1 in ERR.
  - Reasserts on start.
- done and err are registered and mutually exclusive; each stays set until start or rst.
- start in any state other than DONE/ERR is ignored.
- start together with byteValid in DONE/ERR: start wins; the byte is not accepted because byteReady=0.
- Reset values:
  - State LEN_HI, byteReady=1, wrEn=0, wrAddr=0, wrData=0.
  - cpuRst=1, done=0, err=0, errCode=00, wordCnt=0, running XOR=0.
- Reset mid-load: immediate return to reset values. Words already written are not erased; the next load overwrites from address 0.
- Length exactly MAX_WORDS is legal: wrAddr wraps to 0 after the final write, unobservable because the state is CHK.
- Checksum failure does not roll back writes; err plus cpuRst=1 keep the CPU off bad code.

Test Plan:
- Stream 00 02 12 34 AB CD 42 at one byte/cycle:
  - Required writes: wrEn at addr 0 with 0x1234, then addr 1 with 0xABCD.
  - done=1, cpuRst=0, wordCnt=2 the cycle after 0x42 is accepted.
- Same stream with checksum 0x43:
  - Both writes still occur.
  - err=1, errCode=10, cpuRst stays 1, byteReady=0.
- ADDR_W=8, stream 01 01:
  - err=1, errCode=01 after the second byte; no wrEn ever asserted.
- Stream 00 00 00:
  - done=1 with zero writes, wordCnt=0.
- Test-1 stream with random 0-3 cycle byteValid gaps:
  - Writes and result identical to test 1.
  - In DONE, further byteValid pulses are ignored and byteReady=0.
- Restart and reset:
  - Pulse start in DONE, then stream 00 01 BE EF 50: addr 0 gets 0xBEEF; cpuRst is high during the load, then done.
  - Assert rst after 3 bytes of a load: all outputs return to reset values; a fresh valid load then succeeds.
